axi_read_mux: RTL and testbench

Read-path datapath stage for the 4-master AXI interconnect, directly downstream of the read arbiter. It takes the arbiter's one-hot read grants and accepts one AR request from the granted master. It registers that request and forwards it to the single slave port, then routes the R burst back to the owning master until RLAST. It feeds `m_RVALID`/`m_RLAST` back to the arbiter and allows one outstanding read burst at a time.

---
 rtl/axi_read_mux.sv | 256 +++++++++++++++++++++++++
 tb/tb_axi_read_mux.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_mux.sv
// AXI read-path mux: one-hot grant selects a master's AR, registers it
// to the slave, then steers the R burst back to that master until RLAST.
module axi_read_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              m0_rgrnt,
  input  logic              m1_rgrnt,
  input  logic              m2_rgrnt,
  input  logic              m3_rgrnt,
  input  logic [ID_W-1:0]   m0_ARID,
  input  logic [ADDR_W-1:0] m0_ARADDR,
  input  logic [7:0]        m0_ARLEN,
  input  logic [2:0]        m0_ARSIZE,
  input  logic [1:0]        m0_ARBURST,
  input  logic              m0_ARVALID,
  output logic              m0_ARREADY,
  input  logic [ID_W-1:0]   m1_ARID,
  input  logic [ADDR_W-1:0] m1_ARADDR,
  input  logic [7:0]        m1_ARLEN,
  input  logic [2:0]        m1_ARSIZE,
  input  logic [1:0]        m1_ARBURST,
  input  logic              m1_ARVALID,
  output logic              m1_ARREADY,
  input  logic [ID_W-1:0]   m2_ARID,
  input  logic [ADDR_W-1:0] m2_ARADDR,
  input  logic [7:0]        m2_ARLEN,
  input  logic [2:0]        m2_ARSIZE,
  input  logic [1:0]        m2_ARBURST,
  input  logic              m2_ARVALID,
  output logic              m2_ARREADY,
  input  logic [ID_W-1:0]   m3_ARID,
  input  logic [ADDR_W-1:0] m3_ARADDR,
  input  logic [7:0]        m3_ARLEN,
  input  logic [2:0]        m3_ARSIZE,
  input  logic [1:0]        m3_ARBURST,
  input  logic              m3_ARVALID,
  output logic              m3_ARREADY,
  output logic [ID_W-1:0]   m0_RID,
  output logic [DATA_W-1:0] m0_RDATA,
  output logic [1:0]        m0_RRESP,
  output logic              m0_RLAST,
  output logic              m0_RVALID,
  input  logic              m0_RREADY,
  output logic [ID_W-1:0]   m1_RID,
  output logic [DATA_W-1:0] m1_RDATA,
  output logic [1:0]        m1_RRESP,
  output logic              m1_RLAST,
  output logic              m1_RVALID,
  input  logic              m1_RREADY,
  output logic [ID_W-1:0]   m2_RID,
  output logic [DATA_W-1:0] m2_RDATA,
  output logic [1:0]        m2_RRESP,
  output logic              m2_RLAST,
  output logic              m2_RVALID,
  input  logic              m2_RREADY,
  output logic [ID_W-1:0]   m3_RID,
  output logic [DATA_W-1:0] m3_RDATA,
  output logic [1:0]        m3_RRESP,
  output logic              m3_RLAST,
  output logic              m3_RVALID,
  input  logic              m3_RREADY,
  output logic [ID_W-1:0]   s_ARID,
  output logic [ADDR_W-1:0] s_ARADDR,
  output logic [7:0]        s_ARLEN,
  output logic [2:0]        s_ARSIZE,
  output logic [1:0]        s_ARBURST,
  output logic              s_ARVALID,
  input  logic              s_ARREADY,
  input  logic [ID_W-1:0]   s_RID,
  input  logic [DATA_W-1:0] s_RDATA,
  input  logic [1:0]        s_RRESP,
  input  logic              s_RLAST,
  input  logic              s_RVALID,
  output logic              s_RREADY,
  output logic              m_RVALID,
  output logic              m_RLAST,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [1:0] owner;
  logic [7:0] beat;

  logic [3:0] rgrnt;
  logic [3:0] arvalid;
  logic [3:0] rready;
  logic [3:0] arready;
  logic [3:0] rvalid;

  logic [ID_W-1:0]   arid    [4];
  logic [ADDR_W-1:0] araddr  [4];
  logic [7:0]        arlen   [4];
  logic [2:0]        arsize  [4];
  logic [1:0]        arburst [4];

  logic [1:0] sel;
  logic       sel_vld;
  logic       ar_hs;
  logic       r_hs;
  logic       set_err;

  assign rgrnt   = {m3_rgrnt, m2_rgrnt, m1_rgrnt, m0_rgrnt};
  assign arvalid = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
  assign rready  = {m3_RREADY, m2_RREADY, m1_RREADY, m0_RREADY};

  assign arid[0]    = m0_ARID;
  assign arid[1]    = m1_ARID;
  assign arid[2]    = m2_ARID;
  assign arid[3]    = m3_ARID;
  assign araddr[0]  = m0_ARADDR;
  assign araddr[1]  = m1_ARADDR;
  assign araddr[2]  = m2_ARADDR;
  assign araddr[3]  = m3_ARADDR;
  assign arlen[0]   = m0_ARLEN;
  assign arlen[1]   = m1_ARLEN;
  assign arlen[2]   = m2_ARLEN;
  assign arlen[3]   = m3_ARLEN;
  assign arsize[0]  = m0_ARSIZE;
  assign arsize[1]  = m1_ARSIZE;
  assign arsize[2]  = m2_ARSIZE;
  assign arsize[3]  = m3_ARSIZE;
  assign arburst[0] = m0_ARBURST;
  assign arburst[1] = m1_ARBURST;
  assign arburst[2] = m2_ARBURST;
  assign arburst[3] = m3_ARBURST;

  assign m0_ARREADY = arready[0];
  assign m1_ARREADY = arready[1];
  assign m2_ARREADY = arready[2];
  assign m3_ARREADY = arready[3];
  assign m0_RVALID  = rvalid[0];
  assign m1_RVALID  = rvalid[1];
  assign m2_RVALID  = rvalid[2];
  assign m3_RVALID  = rvalid[3];

  assign m0_RID   = s_RID;
  assign m1_RID   = s_RID;
  assign m2_RID   = s_RID;
  assign m3_RID   = s_RID;
  assign m0_RDATA = s_RDATA;
  assign m1_RDATA = s_RDATA;
  assign m2_RDATA = s_RDATA;
  assign m3_RDATA = s_RDATA;
  assign m0_RRESP = s_RRESP;
  assign m1_RRESP = s_RRESP;
  assign m2_RRESP = s_RRESP;
  assign m3_RRESP = s_RRESP;
  assign m0_RLAST = s_RLAST;
  assign m1_RLAST = s_RLAST;
  assign m2_RLAST = s_RLAST;
  assign m3_RLAST = s_RLAST;

  assign busy = (state != IDLE);

  // lowest-index granted master wins when several grants are high
  always_comb begin
    sel     = 2'd0;
    sel_vld = 1'b1;
    if (rgrnt[0])      sel = 2'd0;
    else if (rgrnt[1]) sel = 2'd1;
    else if (rgrnt[2]) sel = 2'd2;
    else if (rgrnt[3]) sel = 2'd3;
    else               sel_vld = 1'b0;
  end

  // state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nx;
  end

  // next state, handshake steering and burst-length checking
  always_comb begin
    state_nx  = state;
    arready   = 4'b0000;
    rvalid    = 4'b0000;
    s_ARVALID = 1'b0;
    s_RREADY  = 1'b0;
    m_RVALID  = 1'b0;
    m_RLAST   = 1'b0;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_vld && !ARESET) begin
          arready[sel] = 1'b1;
          if (arvalid[sel]) begin
            ar_hs    = 1'b1;
            state_nx = ADDR;
          end
        end
      end
      ADDR: begin
        s_ARVALID = 1'b1;
        if (s_ARREADY) state_nx = DATA;
      end
      DATA: begin
        s_RREADY      = rready[owner];
        rvalid[owner] = s_RVALID;
        m_RVALID      = s_RVALID;
        m_RLAST       = s_RLAST;
        if (s_RVALID && rready[owner]) begin
          r_hs = 1'b1;
          if (s_RLAST) begin
            state_nx = IDLE;
            if (beat != s_ARLEN) set_err = 1'b1;
          end else if (beat == s_ARLEN) begin
            set_err = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // AR payload capture, owner/beat tracking, sticky length error
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_ARID    <= '0;
      s_ARADDR  <= '0;
      s_ARLEN   <= '0;
      s_ARSIZE  <= '0;
      s_ARBURST <= '0;
      owner     <= 2'd0;
      beat      <= 8'd0;
      len_err   <= 1'b0;
    end else begin
      if (ar_hs) begin
        s_ARID    <= arid[sel];
        s_ARADDR  <= araddr[sel];
        s_ARLEN   <= arlen[sel];
        s_ARSIZE  <= arsize[sel];
        s_ARBURST <= arburst[sel];
        owner     <= sel;
        beat      <= 8'd0;
      end else if (r_hs) begin
        beat <= beat + 8'd1;
      end
      if (set_err) len_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_read_mux.sv
// Directed bench for axi_read_mux: grant-select table plus
// hand-written burst, stall, error and reset sequences.
module tb_axi_read_mux;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  rgrnt;
  logic [3:0]  arvalid;
  logic [3:0]  rready;
  logic [3:0]  arready;
  logic [3:0]  rvalid;
  logic [3:0]  arid    [4];
  logic [31:0] araddr  [4];
  logic [7:0]  arlen   [4];
  logic [2:0]  arsize  [4];
  logic [1:0]  arburst [4];
  logic [3:0]  rid_o   [4];
  logic [31:0] rdata_o [4];
  logic [1:0]  rresp_o [4];
  logic [3:0]  rlast_o;
  logic [3:0]  s_ARID;
  logic [31:0] s_ARADDR;
  logic [7:0]  s_ARLEN;
  logic [2:0]  s_ARSIZE;
  logic [1:0]  s_ARBURST;
  logic        s_ARVALID;
  logic        s_ARREADY;
  logic [3:0]  s_RID;
  logic [31:0] s_RDATA;
  logic [1:0]  s_RRESP;
  logic        s_RLAST;
  logic        s_RVALID;
  logic        s_RREADY;
  logic        m_RVALID;
  logic        m_RLAST;
  logic        busy;
  logic        len_err;

  int pass_cnt = 0;
  int total    = 0;

  always #5 ACLK = ~ACLK;

  axi_read_mux dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_rgrnt(rgrnt[0]), .m1_rgrnt(rgrnt[1]),
    .m2_rgrnt(rgrnt[2]), .m3_rgrnt(rgrnt[3]),
    .m0_ARID(arid[0]), .m0_ARADDR(araddr[0]), .m0_ARLEN(arlen[0]),
    .m0_ARSIZE(arsize[0]), .m0_ARBURST(arburst[0]),
    .m0_ARVALID(arvalid[0]), .m0_ARREADY(arready[0]),
    .m1_ARID(arid[1]), .m1_ARADDR(araddr[1]), .m1_ARLEN(arlen[1]),
    .m1_ARSIZE(arsize[1]), .m1_ARBURST(arburst[1]),
    .m1_ARVALID(arvalid[1]), .m1_ARREADY(arready[1]),
    .m2_ARID(arid[2]), .m2_ARADDR(araddr[2]), .m2_ARLEN(arlen[2]),
    .m2_ARSIZE(arsize[2]), .m2_ARBURST(arburst[2]),
    .m2_ARVALID(arvalid[2]), .m2_ARREADY(arready[2]),
    .m3_ARID(arid[3]), .m3_ARADDR(araddr[3]), .m3_ARLEN(arlen[3]),
    .m3_ARSIZE(arsize[3]), .m3_ARBURST(arburst[3]),
    .m3_ARVALID(arvalid[3]), .m3_ARREADY(arready[3]),
    .m0_RID(rid_o[0]), .m0_RDATA(rdata_o[0]), .m0_RRESP(rresp_o[0]),
    .m0_RLAST(rlast_o[0]), .m0_RVALID(rvalid[0]), .m0_RREADY(rready[0]),
    .m1_RID(rid_o[1]), .m1_RDATA(rdata_o[1]), .m1_RRESP(rresp_o[1]),
    .m1_RLAST(rlast_o[1]), .m1_RVALID(rvalid[1]), .m1_RREADY(rready[1]),
    .m2_RID(rid_o[2]), .m2_RDATA(rdata_o[2]), .m2_RRESP(rresp_o[2]),
    .m2_RLAST(rlast_o[2]), .m2_RVALID(rvalid[2]), .m2_RREADY(rready[2]),
    .m3_RID(rid_o[3]), .m3_RDATA(rdata_o[3]), .m3_RRESP(rresp_o[3]),
    .m3_RLAST(rlast_o[3]), .m3_RVALID(rvalid[3]), .m3_RREADY(rready[3]),
    .s_ARID(s_ARID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN),
    .s_ARSIZE(s_ARSIZE), .s_ARBURST(s_ARBURST),
    .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
    .s_RID(s_RID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
    .s_RLAST(s_RLAST), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
    .m_RVALID(m_RVALID), .m_RLAST(m_RLAST),
    .busy(busy), .len_err(len_err)
  );

  typedef struct {
    logic [3:0] g;
    logic [3:0] v;
    logic [3:0] exp_rdy;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // issue an AR from master m; leaves the block in ADDR
  task automatic do_ar(input int m, input logic [31:0] a,
                       input logic [7:0] l);
    logic [3:0] one;
    one = 4'b0001 << m;
    rgrnt = one;
    arvalid = one;
    arid[m] = 4'(m + 4);
    araddr[m] = a;
    arlen[m] = l;
    arsize[m] = 3'd2;
    arburst[m] = 2'd1;
    #1;
    chk("ar_ready", arready, one);
    tick();
    arvalid = 4'b0000;
    #1;
    chk("ar_svalid", s_ARVALID, 1);
    chk("ar_saddr", s_ARADDR, a);
    chk("ar_slen", s_ARLEN, l);
    chk("ar_sid", s_ARID, 4'(m + 4));
    chk("ar_rdy_drop", arready, 0);
  endtask

  initial begin
    ARESET = 1'b1;
    rgrnt = 4'b0100;
    arvalid = 4'b0100;
    rready = 4'b0000;
    s_ARREADY = 1'b1;
    s_RID = 4'h0;
    s_RDATA = '0;
    s_RRESP = 2'b00;
    s_RLAST = 1'b0;
    s_RVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      arid[i] = '0;
      araddr[i] = '0;
      arlen[i] = '0;
      arsize[i] = '0;
      arburst[i] = '0;
    end
    #3;
    chk("rst_arready", arready, 0);
    chk("rst_svalid", s_ARVALID, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lenerr", len_err, 0);
    chk("rst_saddr", s_ARADDR, 0);
    chk("rst_srready", s_RREADY, 0);
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    rgrnt = 4'b0000;
    arvalid = 4'b0000;

    vecs[0] = '{4'b0000, 4'b1000, 4'b0000};
    vecs[1] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[2] = '{4'b0110, 4'b0100, 4'b0010};
    vecs[3] = '{4'b0100, 4'b0000, 4'b0100};
    vecs[4] = '{4'b1000, 4'b0100, 4'b1000};
    vecs[5] = '{4'b1111, 4'b1110, 4'b0001};
    vecs[6] = '{4'b1100, 4'b0000, 4'b0100};
    vecs[7] = '{4'b0010, 4'b1101, 4'b0010};
    for (int i = 0; i < 8; i++) begin
      rgrnt = vecs[i].g;
      arvalid = vecs[i].v;
      #1;
      chk($sformatf("sel_rdy[%0d]", i), arready, vecs[i].exp_rdy);
      tick();
      chk($sformatf("sel_idle[%0d]", i), busy, 0);
    end
    arvalid = 4'b0000;

    // m2 burst of 4
    rready = 4'b1111;
    do_ar(2, 32'h1000, 8'd3);
    tick();
    s_RVALID = 1'b1;
    s_RID = 4'd6;
    for (int i = 0; i < 4; i++) begin
      s_RLAST = (i == 3);
      s_RDATA = 32'hA0 + 32'(i);
      #1;
      chk("b1_rvalid", rvalid, 4'b0100);
      chk("b1_srready", s_RREADY, 1);
      chk("b1_rdata", rdata_o[2], 32'hA0 + 32'(i));
      chk("b1_mrlast", m_RLAST, (i == 3));
      tick();
    end
    s_RVALID = 1'b0;
    s_RLAST = 1'b0;
    #1;
    chk("b1_busy", busy, 0);
    chk("b1_lenerr", len_err, 0);
    chk("b1_rvalid_idle", rvalid, 0);

    // slave AR stall while grant moves to m0
    s_ARREADY = 1'b0;
    do_ar(1, 32'h2000, 8'd1);
    rgrnt = 4'b0001;
    arvalid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_saddr", s_ARADDR, 32'h2000);
      chk("st_svalid", s_ARVALID, 1);
      chk("st_m0rdy", arready, 0);
      tick();
    end
    arvalid = 4'b0000;
    s_ARREADY = 1'b1;
    tick();
    s_RVALID = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_RLAST = (i == 1);
      #1;
      chk("st_rvalid", rvalid, 4'b0010);
      tick();
    end
    s_RVALID = 1'b0;
    s_RLAST = 1'b0;
    #1;
    chk("st_busy", busy, 0);

    // owner RREADY toggles; other masters always ready
    do_ar(3, 32'h3000, 8'd1);
    tick();
    s_RVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rready = (i == 1) ? 4'b0111 : 4'b1111;
      s_RLAST = (i == 2);
      #1;
      chk("tg_srready", s_RREADY, (i != 1));
      chk("tg_rvalid", rvalid, 4'b1000);
      tick();
    end
    s_RVALID = 1'b0;
    s_RLAST = 1'b0;
    rready = 4'b1111;
    #1;
    chk("tg_busy", busy, 0);
    chk("tg_lenerr", len_err, 0);

    // early RLAST: ARLEN=1, last on beat 0
    do_ar(0, 32'h4000, 8'd1);
    tick();
    s_RVALID = 1'b1;
    s_RLAST = 1'b1;
    tick();
    s_RVALID = 1'b0;
    s_RLAST = 1'b0;
    #1;
    chk("early_busy", busy, 0);
    chk("early_lenerr", len_err, 1);

    ARESET = 1'b1;
    #1;
    chk("clr_lenerr", len_err, 0);
    tick();
    ARESET = 1'b0;

    // missing RLAST: ARLEN=0, beat 0 without last
    do_ar(0, 32'h5000, 8'd0);
    tick();
    s_RVALID = 1'b1;
    s_RLAST = 1'b0;
    tick();
    chk("late_lenerr", len_err, 1);
    chk("late_busy", busy, 1);
    chk("late_rvalid", rvalid, 4'b0001);
    s_RLAST = 1'b1;
    tick();
    s_RVALID = 1'b0;
    s_RLAST = 1'b0;
    #1;
    chk("late_idle", busy, 0);

    // reset mid-burst after 2 of 4 beats
    do_ar(2, 32'h6000, 8'd3);
    tick();
    s_RVALID = 1'b1;
    tick();
    tick();
    #2;
    ARESET = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_rvalid", rvalid, 0);
    chk("ar_srready", s_RREADY, 0);
    chk("ar_mrvalid", m_RVALID, 0);
    chk("ar_saddr0", s_ARADDR, 0);
    chk("ar_lenerr", len_err, 0);
    tick();
    ARESET = 1'b0;
    s_RVALID = 1'b0;
    do_ar(1, 32'h7000, 8'd0);
    chk("post_busy", busy, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
